// File: rtl/tank_gfx_pkg.sv
// tank_gfx_pkg: shared geometry, types and small helpers for the tank line renderer.
package tank_gfx_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_TOTAL  = 525;
   localparam int unsigned SPR_W    = 18;
   localparam int unsigned SPR_H    = 25;
   localparam int unsigned PIX_W    = 6;
   localparam int unsigned ROW_BITS = SPR_W * PIX_W;

   // Column 0 is the leftmost element, which lands in the MSBs of the flat row.
   typedef logic [0:SPR_W-1][PIX_W-1:0] sprite_row_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_BLUE = 2'b01,
      OWN_RED  = 2'b10
   } owner_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LATCH = 3'd1,
      ST_REQ_B = 3'd2,
      ST_CAP_B = 3'd3,
      ST_REQ_R = 3'd4,
      ST_CAP_R = 3'd5,
      ST_DONE  = 3'd6
   } fetch_state_t;

   // Line that follows y, wrapping at the end of the frame.
   function automatic logic [9:0] next_line(input logic [9:0] y);
      return (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
   endfunction

   // Sprite row to fetch for a row offset; a flipped tank reads bottom-up.
   function automatic logic [4:0] sprite_row(input logic [4:0] dy, input logic flip);
      return flip ? (5'(SPR_H - 1) - dy) : dy;
   endfunction

endpackage

// File: rtl/tank_line_slot.sv
// tank_line_slot: one tank's line buffer (latched x, sprite row, visible flag)
// plus the first pixel-pipeline stage (column hit test and index lookup).
module tank_line_slot
   import tank_gfx_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_clear,
   input  logic [9:0]       i_x,
   input  sprite_row_t      i_row,
   input  logic [9:0]       i_drawx,
   output logic             o_hit,
   output logic [PIX_W-1:0] o_idx
);

   logic [9:0]       r_x;
   sprite_row_t      r_row;
   logic             r_vis;
   logic [9:0]       w_col;
   logic             w_hit;
   logic [PIX_W-1:0] w_idx;

   // Slot contents change only on an explicit load or clear from the fetch FSM.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_x   <= '0;
         r_row <= '0;
         r_vis <= 1'b0;
      end else if (i_load) begin
         r_x   <= i_x;
         r_row <= i_row;
         r_vis <= 1'b1;
      end else if (i_clear) begin
         r_vis <= 1'b0;
      end
   end

   // Unsigned column offset: positions left of the sprite wrap to large values and miss.
   always_comb begin
      w_col = i_drawx - r_x;
      w_hit = r_vis && (w_col < 10'(SPR_W));
      w_idx = '0;
      if (w_hit) begin
         w_idx = r_row[w_col[4:0]];
      end
   end

   // Stage-1 register of the pixel pipeline.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_hit <= 1'b0;
         o_idx <= '0;
      end else begin
         o_hit <= w_hit;
         o_idx <= w_idx;
      end
   end

endmodule

// File: rtl/tank_line_renderer.sv
// tank_line_renderer: fetches the next scanline's sprite rows for both tanks
// during horizontal blank and composites them per pixel with a 2-cycle latency.
module tank_line_renderer
   import tank_gfx_pkg::*;
(
   input  logic                Clk,
   input  logic                Reset,
   input  logic [9:0]          DrawX,
   input  logic [9:0]          DrawY,
   input  logic                hblank_start,
   input  logic [9:0]          blue_x,
   input  logic [9:0]          blue_y,
   input  logic [9:0]          red_x,
   input  logic [9:0]          red_y,
   input  logic                blue_flip,
   input  logic                red_flip,
   output logic                row_req,
   output logic                row_sel,
   output logic [4:0]          row_addr,
   input  logic [ROW_BITS-1:0] row_data,
   output logic [PIX_W-1:0]    pix_idx,
   output logic [1:0]          pix_owner,
   output logic                pix_valid
);

   fetch_state_t     r_state;
   fetch_state_t     w_state_nx;

   logic [9:0]       r_next_y;
   logic [9:0]       r_bx;
   logic [9:0]       r_by;
   logic [9:0]       r_rx;
   logic [9:0]       r_ry;
   logic             r_bflip;
   logic             r_rflip;

   logic [9:0]       w_b_dy;
   logic [9:0]       w_r_dy;
   logic             w_b_in;
   logic             w_r_in;
   logic             w_b_load;
   logic             w_b_clear;
   logic             w_r_load;
   logic             w_r_clear;

   logic             w_b_hit;
   logic             w_r_hit;
   logic [PIX_W-1:0] w_b_idx;
   logic [PIX_W-1:0] w_r_idx;
   logic             w_b_opq;
   logic             w_r_opq;

   logic             r_s1_valid;
   logic [PIX_W-1:0] r_pix_idx;
   owner_t           r_pix_owner;
   logic             r_pix_valid;

   // Fetch FSM state register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next state: a new hblank_start always restarts the fetch from LATCH.
   always_comb begin
      w_state_nx = r_state;
      if (hblank_start) begin
         w_state_nx = ST_LATCH;
      end else begin
         case (r_state)
            ST_IDLE:  w_state_nx = ST_IDLE;
            ST_LATCH: w_state_nx = ST_REQ_B;
            ST_REQ_B: w_state_nx = w_b_in ? ST_CAP_B : ST_REQ_R;
            ST_CAP_B: w_state_nx = ST_REQ_R;
            ST_REQ_R: w_state_nx = w_r_in ? ST_CAP_R : ST_DONE;
            ST_CAP_R: w_state_nx = ST_DONE;
            ST_DONE:  w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
         endcase
      end
   end

   // Snapshot positions and target line so mid-line input changes cannot tear the fetch.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_next_y <= '0;
         r_bx     <= '0;
         r_by     <= '0;
         r_rx     <= '0;
         r_ry     <= '0;
         r_bflip  <= 1'b0;
         r_rflip  <= 1'b0;
      end else if (r_state == ST_LATCH) begin
         r_next_y <= next_line(DrawY);
         r_bx     <= blue_x;
         r_by     <= blue_y;
         r_rx     <= red_x;
         r_ry     <= red_y;
         r_bflip  <= blue_flip;
         r_rflip  <= red_flip;
      end
   end

   // Row offsets and in-range tests; slot updates are suppressed when a fetch is aborted.
   always_comb begin
      w_b_dy    = r_next_y - r_by;
      w_r_dy    = r_next_y - r_ry;
      w_b_in    = w_b_dy < 10'(SPR_H);
      w_r_in    = w_r_dy < 10'(SPR_H);
      w_b_load  = (r_state == ST_CAP_B) && !hblank_start;
      w_r_load  = (r_state == ST_CAP_R) && !hblank_start;
      w_b_clear = (r_state == ST_REQ_B) && !w_b_in && !hblank_start;
      w_r_clear = (r_state == ST_REQ_R) && !w_r_in && !hblank_start;
   end

   // Sprite row read strobe, select and address for the sprite table.
   always_comb begin
      row_req  = 1'b0;
      row_sel  = 1'b0;
      row_addr = '0;
      if ((r_state == ST_REQ_B) && w_b_in) begin
         row_req  = 1'b1;
         row_addr = sprite_row(w_b_dy[4:0], r_bflip);
      end else if ((r_state == ST_REQ_R) && w_r_in) begin
         row_req  = 1'b1;
         row_sel  = 1'b1;
         row_addr = sprite_row(w_r_dy[4:0], r_rflip);
      end
   end

   tank_line_slot u_blue_slot (
      .i_clk   (Clk),
      .i_rst   (Reset),
      .i_load  (w_b_load),
      .i_clear (w_b_clear),
      .i_x     (r_bx),
      .i_row   (row_data),
      .i_drawx (DrawX),
      .o_hit   (w_b_hit),
      .o_idx   (w_b_idx)
   );

   tank_line_slot u_red_slot (
      .i_clk   (Clk),
      .i_rst   (Reset),
      .i_load  (w_r_load),
      .i_clear (w_r_clear),
      .i_x     (r_rx),
      .i_row   (row_data),
      .i_drawx (DrawX),
      .o_hit   (w_r_hit),
      .o_idx   (w_r_idx)
   );

   // Stage 1 active-region flag, aligned with the slot lookup registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
      end
   end

   // Opacity per tank; palette index 0 is transparent.
   always_comb begin
      w_b_opq = w_b_hit && (w_b_idx != '0);
      w_r_opq = w_r_hit && (w_r_idx != '0);
   end

   // Stage 2 compositor: red over blue over background, blanked outside the active area.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_pix_idx   <= '0;
         r_pix_owner <= OWN_NONE;
         r_pix_valid <= 1'b0;
      end else begin
         r_pix_valid <= r_s1_valid;
         if (!r_s1_valid) begin
            r_pix_idx   <= '0;
            r_pix_owner <= OWN_NONE;
         end else if (w_r_opq) begin
            r_pix_idx   <= w_r_idx;
            r_pix_owner <= OWN_RED;
         end else if (w_b_opq) begin
            r_pix_idx   <= w_b_idx;
            r_pix_owner <= OWN_BLUE;
         end else begin
            r_pix_idx   <= '0;
            r_pix_owner <= OWN_NONE;
         end
      end
   end

   assign pix_idx   = r_pix_idx;
   assign pix_owner = r_pix_owner;
   assign pix_valid = r_pix_valid;

endmodule

// File: tb/tb_tank_line_renderer.sv
// tb_tank_line_renderer: randomized scoreboard bench with a behavioural sprite model.
`timescale 1ns/1ps
module tb_tank_line_renderer;
   import tank_gfx_pkg::*;

   logic                Clk;
   logic                Reset;
   logic [9:0]          DrawX;
   logic [9:0]          DrawY;
   logic                hblank_start;
   logic [9:0]          blue_x, blue_y, red_x, red_y;
   logic                blue_flip, red_flip;
   logic                row_req, row_sel;
   logic [4:0]          row_addr;
   logic [ROW_BITS-1:0] row_data = '0;
   logic [PIX_W-1:0]    pix_idx;
   logic [1:0]          pix_owner;
   logic                pix_valid;

   tank_line_renderer dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .DrawX        (DrawX),
      .DrawY        (DrawY),
      .hblank_start (hblank_start),
      .blue_x       (blue_x),
      .blue_y       (blue_y),
      .red_x        (red_x),
      .red_y        (red_y),
      .blue_flip    (blue_flip),
      .red_flip     (red_flip),
      .row_req      (row_req),
      .row_sel      (row_sel),
      .row_addr     (row_addr),
      .row_data     (row_data),
      .pix_idx      (pix_idx),
      .pix_owner    (pix_owner),
      .pix_valid    (pix_valid)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   typedef struct { int sel; int addr; } req_t;
   typedef struct { int stamp; int idx; int own; int vld; } pexp_t;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   req_t        rq[$];
   pexp_t       pq[$];

   // Sprite table contents ([0]=blue, [1]=red) and the model of both line slots.
   sprite_row_t rom   [2][SPR_H];
   bit          m_vis [2];
   int          m_x   [2];
   sprite_row_t m_row [2];

   // Monitor-private state.
   bit          pend = 0;
   int          pend_sel, pend_addr;
   sprite_row_t junk;
   req_t        mr;
   pexp_t       mp;

   function automatic int model_row(input int ly, input int y, input int flip);
      int ny, dy;
      ny = (ly == V_TOTAL - 1) ? 0 : ly + 1;
      dy = (ny - y + 1024) % 1024;
      if (dy >= SPR_H) return -1;
      return (flip != 0) ? (SPR_H - 1 - dy) : dy;
   endfunction

   function automatic void commit(input int t, input int row, input int x);
      m_vis[t] = (row >= 0);
      if (row >= 0) begin
         m_x[t]   = x;
         m_row[t] = rom[t][row];
      end
   endfunction

   function automatic void exp_pix(input int dx, input int dy,
                                   output int idx, output int own, output int vld);
      int c;
      int v[2];
      vld = (dx < H_ACTIVE && dy < V_ACTIVE) ? 1 : 0;
      for (int t = 0; t < 2; t++) begin
         c = (dx - m_x[t] + 1024) % 1024;
         v[t] = (m_vis[t] && c < SPR_W) ? int'(m_row[t][c]) : 0;
      end
      idx = 0;
      own = 0;
      if (vld != 0) begin
         if (v[1] != 0) begin
            idx = v[1];
            own = 2;
         end else if (v[0] != 0) begin
            idx = v[0];
            own = 1;
         end
      end
   endfunction

   // Monitor: sprite-table responder, row-request scoreboard, pixel scoreboard.
   always begin
      @(posedge Clk);
      cyc++;
      #1;
      if (pend) begin
         row_data = rom[pend_sel][pend_addr];
      end else begin
         for (int j = 0; j < SPR_W; j++) junk[j] = 6'($urandom);
         row_data = junk;
      end
      pend = (row_req === 1'b1);
      if (row_req === 1'b1) begin
         total++;
         pend_sel  = int'(row_sel);
         pend_addr = int'(row_addr);
         if (rq.size() == 0) begin
            bad++;
            $display("FAIL row_req_unexpected: got sel=%0d addr=%0d, required no request",
                     row_sel, row_addr);
         end else begin
            mr = rq.pop_front();
            if (row_sel !== 1'(mr.sel) || row_addr !== 5'(mr.addr)) begin
               bad++;
               $display("FAIL row_req: got sel=%0d addr=%0d, required sel=%0d addr=%0d",
                        row_sel, row_addr, mr.sel, mr.addr);
            end
         end
      end
      while (pq.size() > 0 && pq[0].stamp <= cyc - 2) begin
         mp = pq.pop_front();
         total++;
         if (pix_idx !== 6'(mp.idx) || pix_owner !== 2'(mp.own) || pix_valid !== 1'(mp.vld)) begin
            bad++;
            $display("FAIL pixel stamp=%0d: got idx=%0d owner=%0d valid=%0d, required idx=%0d owner=%0d valid=%0d",
                     mp.stamp, pix_idx, pix_owner, pix_valid, mp.idx, mp.own, mp.vld);
         end
      end
   end

   task automatic check_zero(input string name);
      total++;
      if ({row_req, row_sel, row_addr, pix_idx, pix_owner, pix_valid} !== 16'd0) begin
         bad++;
         $display("FAIL %s: got req=%0d sel=%0d addr=%0d idx=%0d owner=%0d valid=%0d, required all 0",
                  name, row_req, row_sel, row_addr, pix_idx, pix_owner, pix_valid);
      end
   endtask

   task automatic check_rq_empty(input string name);
      total++;
      if (rq.size() != 0) begin
         bad++;
         $display("FAIL %s: got %0d outstanding requests, required 0", name, rq.size());
         rq.delete();
      end
   endtask

   task automatic set_pos(input int bx, input int by, input int bf,
                          input int rx, input int ry, input int rf);
      blue_x = 10'(bx); blue_y = 10'(by); blue_flip = 1'(bf);
      red_x  = 10'(rx); red_y  = 10'(ry); red_flip  = 1'(rf);
   endtask

   // Issue a fetch from a negedge; optionally abort it during REQ_B with a second line.
   task automatic fetch(input int ly, input bit abort_, input int ly2,
                        input int bx, input int by, input int bf,
                        input int rx, input int ry, input int rf);
      int rb, rr;
      set_pos(bx, by, bf, rx, ry, rf);
      rb = model_row(ly, by, bf);
      rr = model_row(ly, ry, rf);
      DrawY = 10'(ly);
      DrawX = 10'd700;
      hblank_start = 1'b1;
      if (rb >= 0) rq.push_back('{0, rb});
      if (!abort_ && rr >= 0) rq.push_back('{1, rr});
      @(negedge Clk);
      hblank_start = 1'b0;
      if (abort_) begin
         @(negedge Clk);
         rb = model_row(ly2, by, bf);
         rr = model_row(ly2, ry, rf);
         DrawY = 10'(ly2);
         hblank_start = 1'b1;
         if (rb >= 0) rq.push_back('{0, rb});
         if (rr >= 0) rq.push_back('{1, rr});
         @(negedge Clk);
         hblank_start = 1'b0;
      end
      repeat (8) @(negedge Clk);
      check_rq_empty("req_missing");
      commit(0, rb, bx);
      commit(1, rr, rx);
   endtask

   // Sweep DrawX on one line, scrambling the live position inputs to prove they are latched.
   task automatic scan(input int ly, input int x0, input int n);
      int idx, own, vld, dx;
      DrawY = 10'(ly);
      for (int i = 0; i < n; i++) begin
         dx = (x0 + i) % 1024;
         DrawX = 10'(dx);
         blue_x = 10'($urandom); blue_y = 10'($urandom);
         red_x  = 10'($urandom); red_y  = 10'($urandom);
         exp_pix(dx, ly, idx, own, vld);
         pq.push_back('{cyc, idx, own, vld});
         @(negedge Clk);
      end
      DrawX = 10'd700;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int ly, ny, by, ry, bx, rx, ab, idx, own, vld;
      for (int t = 0; t < 2; t++)
         for (int r = 0; r < SPR_H; r++)
            for (int c = 0; c < SPR_W; c++)
               rom[t][r][c] = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      m_vis[0] = 0; m_vis[1] = 0; m_x[0] = 0; m_x[1] = 0;
      Reset = 1'b1;
      hblank_start = 1'b0;
      DrawX = 10'd700;
      DrawY = 10'd0;
      set_pos(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge Clk);
      check_zero("reset_state");
      Reset = 1'b0;
      @(negedge Clk);
      scan(100, 0, 30);

      // Blue only, red far away.
      rom[0][4][2] = 6'd8;
      rom[0][4][0] = 6'd0;
      fetch(53, 0, 0, 100, 50, 0, 900, 300, 0);
      scan(54, 96, 26);

      // Overlap: red wins, then red transparent lets blue through.
      rom[0][3][5] = 6'd17;
      rom[1][3][5] = 6'd33;
      fetch(12, 0, 0, 200, 10, 0, 200, 10, 0);
      scan(13, 195, 28);
      rom[1][3][5] = 6'd0;
      fetch(12, 0, 0, 200, 10, 0, 200, 10, 0);
      scan(13, 195, 28);

      // Vertical flip: first row, last row, just past the sprite.
      fetch(49, 0, 0, 300, 50, 1, 900, 300, 0);
      scan(50, 295, 26);
      fetch(73, 0, 0, 300, 50, 1, 900, 300, 0);
      scan(74, 295, 26);
      fetch(74, 0, 0, 300, 50, 1, 900, 300, 0);
      scan(75, 295, 26);

      // Frame wrap of next_y.
      fetch(524, 0, 0, 40, 0, 0, 900, 300, 0);
      scan(0, 35, 26);
      fetch(524, 0, 0, 40, 1015, 0, 900, 300, 0);
      scan(0, 35, 26);

      // Horizontal clipping at the right edge and x near 1023.
      fetch(105, 0, 0, 630, 100, 0, 1020, 100, 0);
      scan(106, 620, 30);
      scan(106, 1010, 40);

      // Abort during REQ_B with a different line.
      fetch(205, 1, 210, 150, 200, 0, 400, 200, 1);
      scan(211, 145, 26);
      scan(211, 395, 26);

      // Randomized lines and positions.
      for (int k = 0; k < 40; k++) begin
         ly = ($urandom_range(0, 9) == 0) ? 524 : $urandom_range(0, 524);
         ny = (ly == 524) ? 0 : ly + 1;
         by = (ny + 3 - $urandom_range(0, 30) + 1024) % 1024;
         ry = (ny + 3 - $urandom_range(0, 30) + 1024) % 1024;
         bx = ($urandom_range(0, 3) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 650);
         rx = ($urandom_range(0, 3) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 650);
         ab = ($urandom_range(0, 3) == 0) ? 1 : 0;
         rom[$urandom_range(0, 1)][$urandom_range(0, SPR_H - 1)][$urandom_range(0, SPR_W - 1)] =
            6'($urandom_range(0, 63));
         fetch(ly, 1'(ab), $urandom_range(0, 524), bx, by, $urandom_range(0, 1),
               rx, ry, $urandom_range(0, 1));
         scan($urandom_range(0, 520), (m_x[0] + 1022) % 1024, 22);
         scan($urandom_range(0, 520), (m_x[1] + 1022) % 1024, 22);
      end

      // Asynchronous reset while the red capture is in progress.
      rom[0][10][3] = 6'd7;
      fetch(209, 0, 0, 300, 200, 0, 600, 200, 0);
      repeat (3) @(negedge Clk);
      DrawY = 10'd209;
      DrawX = 10'd303;
      hblank_start = 1'b1;
      rq.push_back('{0, 10});
      rq.push_back('{1, 10});
      @(negedge Clk);
      hblank_start = 1'b0;
      repeat (4) @(posedge Clk);
      #2;
      exp_pix(303, 209, idx, own, vld);
      total++;
      if (pix_idx !== 6'(idx) || pix_owner !== 2'(own) || pix_valid !== 1'(vld)) begin
         bad++;
         $display("FAIL pre_reset_pixel: got idx=%0d owner=%0d valid=%0d, required idx=%0d owner=%0d valid=%0d",
                  pix_idx, pix_owner, pix_valid, idx, own, vld);
      end
      Reset = 1'b1;
      #1;
      check_zero("reset_async_capr");
      check_rq_empty("req_before_reset");
      m_vis[0] = 0;
      m_vis[1] = 0;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      scan(210, 290, 20);
      scan(210, 595, 20);

      repeat (5) @(negedge Clk);
      total++;
      if (pq.size() != 0) begin
         bad++;
         $display("FAIL pixel_drain: got %0d unchecked pixels, required 0", pq.size());
      end
      check_rq_empty("req_drain");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
